// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the BCD <-> binary converters.
//   bcd_state_t            : converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_W            : width of one packed BCD digit
//   ADJ_THRESH/ADJ_OFFSET  : reverse double-dabble correction (>= 8 -> -3)
//   B2D_THRESH/B2D_OFFSET  : forward double-dabble correction (>= 5 -> +3)
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } bcd_state_t;

   localparam int BCD_DIGIT_W = 4;

   // BCD -> binary: after a right shift a column >= 8 received a bit worth
   // 10 in decimal but 16 in binary weight of its neighbour; subtract 3.
   localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd8;
   localparam logic [BCD_DIGIT_W-1:0] ADJ_OFFSET = 4'd3;

   // Binary -> BCD counterpart (used by the display converter).
   localparam logic [BCD_DIGIT_W-1:0] B2D_THRESH = 4'd5;
   localparam logic [BCD_DIGIT_W-1:0] B2D_OFFSET = 4'd3;

endpackage : bcd_pkg

// File: rtl/bcd_binary_if.sv
// -----------------------------------------------------------------------------
// bcd_binary_if
// Request/result bundle of the BCD-to-binary converter.
//   bcd_in    : packed BCD request operand, digit 0 in [3:0]
//   valid     : request strobe
//   busy      : converter not in IDLE
//   bin_code  : converted value, held until the next completion
//   bin_ready : one-cycle completion pulse
//   bcd_error : qualifies bin_ready, set when an input digit was > 9
//   state     : FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where valid = 1 and
// busy = 0. While busy is high valid is ignored and nothing is queued; a
// requester that wants service keeps valid high until busy is low. The
// result is signalled by exactly one cycle of bin_ready, with bcd_error
// qualifying it; bin_code stays stable afterwards.
// -----------------------------------------------------------------------------
interface bcd_binary_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);

   logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
   logic                          valid;
   logic                          busy;
   logic [BIN_W-1:0]              bin_code;
   logic                          bin_ready;
   logic                          bcd_error;
   bcd_state_t                    state;

   modport master (
      output bcd_in, valid,
      input  busy, bin_code, bin_ready, bcd_error, state
   );

   modport slave (
      input  bcd_in, valid,
      output busy, bin_code, bin_ready, bcd_error, state
   );

endinterface : bcd_binary_if

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// One BCD column correction for reverse double-dabble, purely combinational.
//   d_in  : 4-bit column value after the shift
//   d_out : d_in - 3 when d_in >= 8, else d_in (modulo 16)
// -----------------------------------------------------------------------------
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_in,
   output logic [BCD_DIGIT_W-1:0] d_out
);

   assign d_out = (d_in >= ADJ_THRESH) ? (d_in - ADJ_OFFSET) : d_in;

endmodule : bcd_digit_adjust

// File: rtl/bcd_binary.sv
// -----------------------------------------------------------------------------
// bcd_binary
// Sequential BCD-to-binary converter (reverse double-dabble, one shift and
// correct step per clock).
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : bcd_binary_if.slave (request in, result/status out)
// Parameters:
//   DIGITS  : number of BCD input digits
//   BIN_W   : binary output width, must hold 10^DIGITS - 1 and be <= 4*DIGITS
// -----------------------------------------------------------------------------
module bcd_binary
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic         clk,
   input  logic         reset_n,
   bcd_binary_if.slave  bus
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = 2 * BCD_W;
   localparam int ITER  = BCD_W;
   localparam int CNT_W = $clog2(ITER + 1);

   bcd_state_t        state_q;
   bcd_state_t        state_d;
   logic [SR_W-1:0]   sr_q;
   logic [SR_W-1:0]   sr_shift;
   logic [SR_W-1:0]   sr_adj;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIN_W-1:0]  bin_code_q;
   logic              err_q;
   logic [DIGITS-1:0] digit_bad;
   logic              any_bad;
   logic              accept;
   logic              last_iter;

   // Upper half holds the remaining BCD digits, lower half collects binary
   // bits as they fall out of digit 0.
   assign sr_shift = sr_q >> 1;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_col
         bcd_digit_adjust u_adj (
            .d_in  (sr_shift[BCD_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .d_out (sr_adj  [BCD_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
         );

         // 10..15 are the only non-decimal codes: bit 3 plus bit 2 or bit 1.
         assign digit_bad[g] = bus.bcd_in[BCD_DIGIT_W*g + 3] &
                               (bus.bcd_in[BCD_DIGIT_W*g + 2] |
                                bus.bcd_in[BCD_DIGIT_W*g + 1]);
      end
   endgenerate

   assign sr_adj[BCD_W-1:0] = sr_shift[BCD_W-1:0];

   assign any_bad   = |digit_bad;
   assign accept    = (state_q == IDLE) && bus.valid;
   assign last_iter = (cnt_q == CNT_W'(ITER - 1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.valid) begin
               state_d = any_bad ? DONE : CONV;
            end
         end
         CONV: begin
            if (last_iter) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      bus.busy      = 1'b0;
      bus.bin_ready = 1'b0;
      case (state_q)
         CONV: bus.busy = 1'b1;
         DONE: begin
            bus.busy      = 1'b1;
            bus.bin_ready = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.bin_code  = bin_code_q;
   assign bus.bcd_error = err_q;
   assign bus.state     = state_q;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         bin_code_q <= '0;
         err_q      <= 1'b0;
      end else if (accept) begin
         sr_q  <= {bus.bcd_in, {BCD_W{1'b0}}};
         cnt_q <= '0;
         if (any_bad) begin
            bin_code_q <= '0;
            err_q      <= 1'b1;
         end
      end else if (state_q == CONV) begin
         sr_q  <= sr_adj;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last_iter) begin
            // Bits above BIN_W are zero for any legal input; dropped.
            bin_code_q <= sr_adj[BIN_W-1:0];
            err_q      <= 1'b0;
         end
      end
   end

endmodule : bcd_binary

// File: tb/tb_bcd_binary.sv
// -----------------------------------------------------------------------------
// tb_bcd_binary
// Self-checking bench for bcd_binary (DIGITS=4, BIN_W=14).
// -----------------------------------------------------------------------------
module tb_bcd_binary;
   import bcd_pkg::*;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;
   localparam int LAT    = 4 * DIGITS;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   bcd_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // ------------------------------------------------------- clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of the digits, error if any digit exceeds 9.
   task automatic model(input logic [15:0] bcd, output logic [31:0] val, output logic err);
      logic [3:0] d;
      val = 0;
      err = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d   = bcd[4*i +: 4];
         if (d > 4'd9) err = 1'b1;
         val = val * 10 + 32'(d);
      end
      if (err) val = 0;
   endtask

   // Binary-to-BCD reference used for the round trip.
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- driver
   // Called just after a rising edge; presents one request for one cycle and
   // checks the whole response, ending one cycle after the DONE cycle.
   task automatic run_req(input logic [15:0] bcd, input string tag);
      logic [31:0] exp_val;
      logic        exp_err;
      int          cyc;
      int          busy_n;
      model(bcd, exp_val, exp_err);
      bus.bcd_in = bcd;
      bus.valid  = 1'b1;
      @(posedge clk); #1;
      bus.valid  = 1'b0;
      bus.bcd_in = 16'($urandom);     // must not disturb the latched operand
      if (exp_err) begin
         check({tag, "_err_ready"}, 32'(bus.bin_ready), 32'd1);
         check({tag, "_err_flag"},  32'(bus.bcd_error), 32'd1);
         check({tag, "_err_code"},  32'(bus.bin_code),  32'd0);
      end else begin
         cyc    = 0;
         busy_n = 0;
         while (bus.bin_ready !== 1'b1 && cyc < 3 * LAT) begin
            busy_n += int'(bus.busy);
            @(posedge clk); #1;
            cyc++;
         end
         busy_n += int'(bus.busy);
         check({tag, "_latency"}, 32'(cyc),           32'(LAT));
         check({tag, "_busy_n"},  32'(busy_n),        32'(LAT + 1));
         check({tag, "_code"},    32'(bus.bin_code),  exp_val);
         check({tag, "_err"},     32'(bus.bcd_error), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, 32'(bus.bin_ready), 32'd0);
      check({tag, "_idle"},      32'(bus.busy),      32'd0);
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      int          cyc;
      int          rdy_n;
      int          v;
      logic [15:0] raw;

      n_cmp       = 0;
      n_bad       = 0;
      reset_n     = 1'b0;
      bus.valid   = 1'b0;
      bus.bcd_in  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  32'(bus.busy),      32'd0);
      check("rst_ready", 32'(bus.bin_ready), 32'd0);
      check("rst_code",  32'(bus.bin_code),  32'd0);
      check("rst_err",   32'(bus.bcd_error), 32'd0);
      check("rst_state", 32'(bus.state),     32'(IDLE));
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed conversions, including the error path and its clearing.
      run_req(16'h1234, "d1234");
      run_req(16'h9999, "d9999");
      run_req(16'h0000, "d0000");
      run_req(16'h12A4, "bad12A4");
      check("err_sticky", 32'(bus.bcd_error), 32'd1);
      run_req(16'h0042, "d0042");
      run_req(16'hF000, "badF000");

      // Requests during CONV and DONE are dropped; held into IDLE -> accepted.
      bus.bcd_in = 16'h0500;
      bus.valid  = 1'b1;
      @(posedge clk); #1;
      bus.bcd_in = 16'h0007;
      cyc = 0;
      while (bus.bin_ready !== 1'b1 && cyc < 3 * LAT) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("hold_latency", 32'(cyc),          32'(LAT));
      check("hold_code500", 32'(bus.bin_code), 32'd500);
      @(posedge clk); #1;
      check("hold_idle",    32'(bus.busy),     32'd0);
      run_req(16'h0007, "hold7");

      // Reset in the middle of a conversion.
      bus.bcd_in = 16'h8765;
      bus.valid  = 1'b1;
      @(posedge clk); #1;
      bus.valid  = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("mid_busy_pre", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_busy",  32'(bus.busy),      32'd0);
      check("mid_ready", 32'(bus.bin_ready), 32'd0);
      check("mid_code",  32'(bus.bin_code),  32'd0);
      check("mid_err",   32'(bus.bcd_error), 32'd0);
      check("mid_state", 32'(bus.state),     32'(IDLE));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rdy_n = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(posedge clk); #1;
         rdy_n += int'(bus.bin_ready);
      end
      check("mid_no_ready", 32'(rdy_n), 32'd0);
      run_req(16'h0001, "after_rst");

      // Random raw words, legal or not.
      for (int i = 0; i < 60; i++) begin
         raw = 16'($urandom);
         run_req(raw, "rand_raw");
      end

      // Round trip: decimal -> BCD -> converter, must return the original.
      for (int i = 0; i < 1000; i++) begin
         v = int'($urandom_range(0, 9999));
         run_req(to_bcd(v), "round_trip");
         check("round_trip_val", 32'(bus.bin_code), 32'(v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bcd_binary
